// File: rtl/alu_seq_pkg.sv
// Shared types and op-select constants for the nibble-serial ALU sequencer.
// The op class comes from s3s2; the arithmetic variant comes from s1s0.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ARITH = 2'b00,
    LOGIC = 2'b01,
    SHR   = 2'b10,
    SHL   = 2'b11
  } op_class_e;

  localparam logic [1:0] XFER = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;
  localparam logic [1:0] DEC  = 2'b11;

endpackage

// File: rtl/alu_seq_if.sv
// Command and result handshakes between the control path (master) and the sequencer (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_s;
  logic             cmd_cin;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_f;
  logic             res_cout;

  modport master (
    output cmd_valid, cmd_s, cmd_cin, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_f, res_cout
  );

  modport slave (
    input  cmd_valid, cmd_s, cmd_cin, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_f, res_cout
  );
endinterface

// File: rtl/nib_patch.sv
// Fixes the bit that crosses a nibble boundary on shifts; a 4-bit shift
// alone cannot see its neighbour nibble.
module nib_patch
  import alu_seq_pkg::*;
(
  input  logic [3:0] alu_f,
  input  op_class_e  op_class,
  input  logic       nb_hi,
  input  logic       nb_lo,
  input  logic       is_top,
  input  logic       is_bot,
  output logic [3:0] f_patched
);

  always_comb begin
    // NOTE: assign a default before any branch so every path drives the output and no latch is inferred.
    f_patched = alu_f;
    case (op_class)
      SHR:     f_patched[3] = is_top ? 1'b0 : nb_hi;
      SHL:     f_patched[0] = is_bot ? 1'b0 : nb_lo;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Drives an external 4-bit alu through WIDTH/4 nibble steps, LSB nibble first,
// chaining the carry between steps; one command in, one result out.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic [3:0] alu_s,
  output logic       alu_cin,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_f,
  input  logic       alu_cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("alu_sequencer: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [3:0]       s_q, s_d;
  logic             cin_q, cin_d, carry_q, carry_d;

  op_class_e  op_class;
  logic [3:0] a_nib, b_nib, f_patched;
  logic       nb_hi, nb_lo, is_top, is_bot;

  assign op_class = op_class_e'(s_q[3:2]);
  assign is_top   = (idx_q == LAST);
  assign is_bot   = (idx_q == '0);

  // Neighbour indices wrap modulo WIDTH; the wrapped bit is masked by is_top/is_bot.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    nb_hi = 1'b0;
    nb_lo = 1'b0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
        nb_hi = a_q[(4*n + 4) % WIDTH];
        nb_lo = a_q[(4*n + WIDTH - 1) % WIDTH];
      end
    end
  end

  nib_patch u_nib_patch (
    .alu_f     (alu_f),
    .op_class  (op_class),
    .nb_hi     (nb_hi),
    .nb_lo     (nb_lo),
    .is_top    (is_top),
    .is_bot    (is_bot),
    .f_patched (f_patched)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    s_d     = s_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = RUN;
          idx_d   = '0;
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          s_d     = bus.cmd_s;
          cin_d   = bus.cmd_cin;
        end
      end
      RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDX_W'(n)) r_d[4*n +: 4] = f_patched;
        end
        carry_d = alu_cout;
        if (is_top) state_d = DONE;
        else        idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU-facing outputs depend on registered state only, never on alu_f/alu_cout.
  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.res_valid = (state_q == DONE);
    alu_s   = '0;
    alu_cin = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    if (state_q == RUN) begin
      alu_s   = s_q;
      alu_cin = is_bot ? cin_q : carry_q;
      alu_a   = a_nib;
      alu_b   = b_nib;
    end
    case (op_class)
      ARITH:   bus.res_cout = carry_q;
      SHR:     bus.res_cout = a_q[0];
      SHL:     bus.res_cout = a_q[WIDTH-1];
      default: bus.res_cout = 1'b0;
    endcase
  end

  assign bus.res_f = r_q;

endmodule
